// File: rtl/pattern_histogram_pkg.sv
// Shared types and default constants for the pattern histogram scanner.
package pattern_histogram_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_PAT, SCAN, WRITE, DONE} state_t;

  localparam logic [7:0] DEF_BASE_ADDR = 8'd32;
  localparam int         DEF_NUM_BYTES = 64;
  localparam logic [7:0] DEF_PAT_ADDR  = 8'd9;
  localparam logic [7:0] DEF_HIST_ADDR = 8'd10;
  localparam int         CNT_W         = 8;
  localparam int         NUM_BINS      = 5;
endpackage

// File: rtl/pattern_histogram_if.sv
// Data memory port: the scanner drives address/write, memory returns read data.
interface pattern_histogram_if;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;

  modport master (output mem_addr, output mem_wr_en, output mem_wr_data, input mem_rd_data);
  modport slave  (input mem_addr, input mem_wr_en, input mem_wr_data, output mem_rd_data);
endinterface

// File: rtl/pattern_histogram_nibble_match.sv
// Counts how many of the five 4-bit windows of a byte equal the pattern.
module nibble_match (
  input  logic [7:0] data,
  input  logic [3:0] pattern,
  output logic [2:0] m
);
  logic [4:0] hit;

  for (genvar gi = 0; gi < 5; gi++) begin : g_hit
    assign hit[gi] = (data[gi+3:gi] == pattern);
  end

  always_comb begin
    m = '0;
    for (int k = 0; k < 5; k++) m = m + {2'b00, hit[k]};
  end
endmodule

// File: rtl/pattern_histogram.sv
// Scans a byte range for 4-bit pattern occurrences and writes a 5-bin
// histogram (bins = matches per byte, 1..5) back to memory.
module pattern_histogram
  import pattern_histogram_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int         NUM_BYTES = DEF_NUM_BYTES,
  parameter logic [7:0] PAT_ADDR  = DEF_PAT_ADDR,
  parameter logic [7:0] HIST_ADDR = DEF_HIST_ADDR
) (
  input  logic CLK,
  input  logic Reset,
  input  logic start,
  output logic Halt,
  pattern_histogram_if.master mem
);
  state_t           state;
  logic [3:0]       pattern;
  logic [8:0]       index;
  logic [CNT_W-1:0] counter [1:NUM_BINS];
  logic [CNT_W-1:0] cnt_upd [1:NUM_BINS];
  logic [CNT_W-1:0] next_wr_data;
  logic [2:0]       m;

  nibble_match u_match (
    .data    (mem.mem_rd_data),
    .pattern (pattern),
    .m       (m)
  );

  // Counters as they will be after the byte currently on the bus is counted.
  for (genvar gi = 1; gi <= NUM_BINS; gi++) begin : g_upd
    assign cnt_upd[gi] = (m == 3'(gi) && counter[gi] != '1) ? counter[gi] + 1'b1
                                                              : counter[gi];
  end

  // Data for the write slot following slot index[2:0].
  always_comb begin
    next_wr_data = '0;
    case (index[2:0])
      3'd0:    next_wr_data = counter[2];
      3'd1:    next_wr_data = counter[3];
      3'd2:    next_wr_data = counter[4];
      3'd3:    next_wr_data = counter[5];
      default: next_wr_data = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state           <= IDLE;
      Halt            <= 1'b0;
      mem.mem_wr_en   <= 1'b0;
      mem.mem_wr_data <= '0;
      mem.mem_addr    <= PAT_ADDR;
      pattern         <= '0;
      index           <= '0;
      for (int j = 1; j <= NUM_BINS; j++) counter[j] <= '0;
    end else if (start) begin
      state           <= IDLE;
      Halt            <= 1'b0;
      mem.mem_wr_en   <= 1'b0;
      mem.mem_addr    <= PAT_ADDR;
      index           <= '0;
      for (int j = 1; j <= NUM_BINS; j++) counter[j] <= '0;
    end else begin
      case (state)
        IDLE: begin
          mem.mem_addr <= PAT_ADDR;
          index        <= '0;
          for (int j = 1; j <= NUM_BINS; j++) counter[j] <= '0;
          state        <= LOAD_PAT;
        end
        LOAD_PAT: begin
          pattern      <= mem.mem_rd_data[3:0];
          mem.mem_addr <= BASE_ADDR;
          index        <= '0;
          state        <= SCAN;
        end
        SCAN: begin
          for (int j = 1; j <= NUM_BINS; j++) counter[j] <= cnt_upd[j];
          if (index == 9'(NUM_BYTES - 1)) begin
            // First write slot is presented on the same edge the last byte is counted.
            state           <= WRITE;
            index           <= '0;
            mem.mem_wr_en   <= 1'b1;
            mem.mem_addr    <= HIST_ADDR;
            mem.mem_wr_data <= cnt_upd[1];
          end else begin
            index        <= index + 1'b1;
            mem.mem_addr <= BASE_ADDR + index[7:0] + 8'd1;
          end
        end
        WRITE: begin
          if (index[2:0] == 3'd4) begin
            state         <= DONE;
            mem.mem_wr_en <= 1'b0;
            Halt          <= 1'b1;
          end else begin
            index           <= index + 1'b1;
            mem.mem_addr    <= HIST_ADDR + index[7:0] + 8'd1;
            mem.mem_wr_data <= next_wr_data;
          end
        end
        DONE: begin
          Halt          <= 1'b1;
          mem.mem_wr_en <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pattern_histogram.sv
// Randomised and directed runs against a behavioural histogram model with a write scoreboard.
module tb_pattern_histogram;
  import pattern_histogram_pkg::*;

  localparam int BASE = 32;
  localparam int HIST = 10;
  localparam int NB   = 64;

  logic CLK = 1'b0;
  logic Reset;
  logic start;
  logic Halt;

  pattern_histogram_if bus ();

  pattern_histogram dut (
    .CLK   (CLK),
    .Reset (Reset),
    .start (start),
    .Halt  (Halt),
    .mem   (bus)
  );

  always #5 CLK = ~CLK;

  logic [7:0] mem [256];
  assign bus.mem_rd_data = mem[bus.mem_addr];
  always @(posedge CLK) if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wr_data;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;
  wr_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int wr_pulses = 0;

  logic [7:0] data_bytes [NB];
  logic [7:0] exp_hist [1:5];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the next queued write.
  always @(negedge CLK) begin
    if (!Reset && bus.mem_wr_en) begin
      wr_pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write addr=%0d data=%0d required=none", bus.mem_addr, bus.mem_wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        $display("WR addr=%0d data=%0d exp_addr=%0d exp_data=%0d", bus.mem_addr, bus.mem_wr_data, e.addr, e.data);
        check("wr_addr", int'(bus.mem_addr), int'(e.addr));
        check("wr_data", int'(bus.mem_wr_data), int'(e.data));
      end
    end
  end

  // Histogram from the rules: count windows equal to the pattern, bin by count.
  task automatic ref_hist(input logic [3:0] pat);
    for (int j = 1; j <= 5; j++) exp_hist[j] = 8'd0;
    for (int i = 0; i < NB; i++) begin
      int mc = 0;
      for (int k = 0; k < 5; k++)
        if (((int'(data_bytes[i]) >> k) & 15) == int'(pat)) mc++;
      if (mc > 0 && exp_hist[mc] != 8'hFF) exp_hist[mc] = exp_hist[mc] + 8'd1;
    end
  endtask

  task automatic preload(input logic [3:0] pat, input logic [7:0] sentinel);
    mem[9] <= {4'($urandom_range(0, 15)), pat};
    for (int i = 0; i < NB; i++) mem[8'(BASE + i)] <= data_bytes[i];
    for (int j = 0; j < 5; j++) mem[8'(HIST + j)] <= sentinel;
    #1;
  endtask

  task automatic run_test(input string name, input logic [3:0] pat);
    int n;
    preload(pat, 8'hA5);
    ref_hist(pat);
    for (int j = 0; j < 5; j++) exp_q.push_back('{addr: 8'(HIST + j), data: exp_hist[j+1]});
    wr_pulses = 0;
    @(negedge CLK);
    start = 1'b0;
    @(posedge CLK);
    n = 0;
    #1;
    while (!Halt && n < 300) begin
      @(posedge CLK);
      #1;
      n++;
    end
    $display("RUN %s pat=%0h latency=%0d hist=%0d,%0d,%0d,%0d,%0d", name, pat, n,
             mem[10], mem[11], mem[12], mem[13], mem[14]);
    check({name, "_latency"}, n, NB + 6);
    check({name, "_halt"}, int'(Halt), 1);
    check({name, "_wr_pulses"}, wr_pulses, 5);
    check({name, "_queue_drained"}, exp_q.size(), 0);
    for (int j = 0; j < 5; j++) check({name, "_hist"}, int'(mem[8'(HIST + j)]), int'(exp_hist[j+1]));
    exp_q.delete();
    @(negedge CLK);
    start = 1'b1;
    @(posedge CLK);
    #1;
    check({name, "_halt_clear"}, int'(Halt), 0);
  endtask

  task automatic wait_addr(input int addr, input logic want_wr, output bit found);
    found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      @(negedge CLK);
      if (int'(bus.mem_addr) == addr && bus.mem_wr_en == want_wr) found = 1'b1;
    end
  endtask

  initial begin
    bit found;
    Reset = 1'b1;
    start = 1'b1;
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    #1;
    check("reset_halt", int'(Halt), 0);
    check("reset_wr_en", int'(bus.mem_wr_en), 0);
    check("reset_addr", int'(bus.mem_addr), 9);
    check("reset_wr_data", int'(bus.mem_wr_data), 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < NB; i++) data_bytes[i] = 8'h00;
    data_bytes[0] = 8'h22;
    run_test("single_22", 4'b0010);

    for (int i = 0; i < NB; i++) data_bytes[i] = 8'h00;
    run_test("all_zero", 4'b0000);

    for (int i = 0; i < NB; i++) data_bytes[i] = 8'h00;
    for (int i = 0; i < 4; i++) data_bytes[i] = 8'hFF;
    data_bytes[4] = 8'h0F;
    run_test("ones", 4'b1111);

    for (int i = 0; i < NB; i++) data_bytes[i] = 8'($urandom);
    run_test("random_p2", 4'b0010);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NB; i++) data_bytes[i] = 8'($urandom);
      run_test("random_px", 4'($urandom_range(0, 15)));
    end

    // Reset pulsed mid-scan: no writes expected, results untouched.
    for (int i = 0; i < NB; i++) data_bytes[i] = 8'($urandom);
    preload(4'b0010, 8'h5A);
    @(negedge CLK);
    start = 1'b0;
    wait_addr(BASE + 20, 1'b0, found);
    check("scan20_reached", int'(found), 1);
    Reset = 1'b1;
    #1;
    check("midscan_rst_halt", int'(Halt), 0);
    check("midscan_rst_wr_en", int'(bus.mem_wr_en), 0);
    check("midscan_rst_addr", int'(bus.mem_addr), 9);
    start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b0;
    repeat (3) @(negedge CLK);
    for (int j = 0; j < 5; j++) check("midscan_hist_kept", int'(mem[8'(HIST + j)]), 8'h5A);
    run_test("after_reset", 4'b0010);

    // start raised during write slot 2: slots 3 and 4 must not be written.
    for (int i = 0; i < NB; i++) data_bytes[i] = 8'($urandom);
    preload(4'b0110, 8'h3C);
    ref_hist(4'b0110);
    for (int j = 0; j < 3; j++) exp_q.push_back('{addr: 8'(HIST + j), data: exp_hist[j+1]});
    @(negedge CLK);
    start = 1'b0;
    wait_addr(HIST + 2, 1'b1, found);
    check("write2_reached", int'(found), 1);
    start = 1'b1;
    @(posedge CLK);
    #1;
    check("abort_wr_en", int'(bus.mem_wr_en), 0);
    check("abort_halt", int'(Halt), 0);
    check("abort_addr", int'(bus.mem_addr), 9);
    repeat (4) @(negedge CLK);
    check("abort_halt_stays", int'(Halt), 0);
    check("abort_queue_drained", exp_q.size(), 0);
    check("abort_hist12", int'(mem[12]), int'(exp_hist[3]));
    check("abort_hist13_kept", int'(mem[13]), 8'h3C);
    check("abort_hist14_kept", int'(mem[14]), 8'h3C);
    exp_q.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pattern_histogram.md
PATTERN_HISTOGRAM -- requirements
Module: pattern_histogram

Interface
REQ-001 Parameter BASE_ADDR, default 8'd32, first data byte address scanned.
REQ-002 Parameter NUM_BYTES, default 64, number of consecutive bytes scanned.
REQ-003 Parameter PAT_ADDR, default 8'd9, address whose bits [3:0] hold the 4-bit pattern.
REQ-004 Parameter HIST_ADDR, default 8'd10, first of five histogram result addresses.
REQ-005 CLK  input  1  single system clock, rising-edge active.
REQ-006 Reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  1: hold/initialise; 0: run.
REQ-008 Halt  output  1  done flag.
REQ-009 mem_addr  output  8  data memory address.
REQ-010 mem_rd_data  input  8  data memory read data, combinational from mem_addr in the same cycle.
REQ-011 mem_wr_en  output  1  data memory write enable, sampled by memory at the rising CLK edge.
REQ-012 mem_wr_data  output  8  data memory write data.

Function
REQ-013 The FSM SHALL have states IDLE, LOAD_PAT, SCAN, WRITE, DONE.
REQ-014 IDLE: mem_wr_en=0, Halt=0, mem_addr=PAT_ADDR; 5 counters and byte index cleared; go to LOAD_PAT on the first edge with start=0.
REQ-015 LOAD_PAT (1 cycle): mem_addr=PAT_ADDR; latch mem_rd_data[3:0] as pattern; go to SCAN.
REQ-016 SCAN (NUM_BYTES cycles): mem_addr=BASE_ADDR+index; per byte, m = count of k in 0..4 with byte[k+3:k]==pattern; m in 1..5 increments counter[m]; m=0 changes nothing; index increments; after index NUM_BYTES-1 go to WRITE.
REQ-017 Address arithmetic SHALL be 8-bit modulo 256 (wraps past 8'hFF).
REQ-018 Counters SHALL be 8-bit and saturate at 8'hFF (unreachable at default NUM_BYTES).
REQ-019 WRITE (5 cycles): cycle j=0..4 drives mem_wr_en=1, mem_addr=HIST_ADDR+j, mem_wr_data=counter[j+1]; then DONE.
REQ-020 DONE: Halt=1, mem_wr_en=0; remain until start=1.
REQ-021 start=1 in any state SHALL return the FSM to IDLE on the next edge, aborting without further writes; Halt falls the same edge.
REQ-022 Latency: Halt SHALL rise exactly NUM_BYTES+6 rising edges after the first edge sampling start=0 (70 at defaults).
REQ-023 mem_wr_en SHALL be 0 in every state except WRITE.
REQ-024 Histogram locations overlapping the scan range SHALL be scanned before being written (scan always precedes write).

Reset
REQ-025 Reset=1 SHALL immediately force state IDLE, Halt=0, mem_wr_en=0, mem_wr_data=0, mem_addr=PAT_ADDR, counters=0, index=0, pattern=0, independent of CLK.
REQ-026 Reset asserted mid-SCAN or mid-WRITE SHALL abandon the run; already-written histogram bytes remain in memory.
REQ-027 After Reset release, operation SHALL resume per REQ-014 (start=0 launches a run).

Structure
REQ-028 Package pattern_histogram_pkg SHALL hold the state enum type, default address constants, and counter width.
REQ-029 Combinational sub-module nibble_match SHALL take byte and 4-bit pattern and output 3-bit m (0..5).
REQ-030 Counter, index and pattern registers SHALL reside in pattern_histogram; no memory inside the block.

Verification
REQ-031 Pattern 0010, byte 0x22 at 32, all other bytes 0x00 -> counter[2]=1 (bits[7:4],[3:0] match); mem[10..14]=0,1,0,0,0.
REQ-032 Pattern 0000, all 64 bytes 0x00 -> mem[10..14]=0,0,0,0,64; Halt rises 70 edges after start falls.
REQ-033 Pattern 1111, bytes 0xFF at 32..35, 0x0F at 36, rest 0x00 -> mem[10..14]=1,0,0,0,4.
REQ-034 Pattern 0010, 64 seeded random bytes -> mem[10..14] equals a five-position reference model histogram; mem_wr_en pulses only 5 cycles.
REQ-035 Reset pulsed at SCAN index 20 -> Halt=0, mem_wr_en=0 immediately, mem[10..14] unchanged; next start=0 run gives correct histogram.
REQ-036 start raised during WRITE cycle 2 -> mem[13],mem[14] not written; FSM in IDLE next edge; Halt stays 0.
